nic_seq_ctrl: RTL and testbench

//  CPU-side sequencer for the NIC register bus (addr/nicEn/nicEnWR/d_in/d_out).

---
 rtl/nic_pkg.sv | 25 ++
 rtl/nic_seq_ctrl_if.sv | 26 ++
 rtl/nic_poll_timer.sv | 35 +++
 rtl/nic_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_nic_seq_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nic_pkg.sv
// Shared NIC register-bus addresses, sequencer state encoding and arbitration side type.
package nic_pkg;

   localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
   localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
   localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      TX_POLL,
      TX_CHK,
      TX_WR,
      RX_POLL,
      RX_CHK,
      RX_RD,
      RX_CAP
   } seq_state_t;

   typedef enum logic {
      TX,
      RX
   } rr_side_t;

endpackage

// File: rtl/nic_seq_ctrl_if.sv
// Core-side TX/RX streams plus the NIC register bus, bundled for the sequencer.
interface nic_seq_ctrl_if #(
   parameter int PACKET_WIDTH = 64
);
   logic                    tx_valid;
   logic                    tx_ready;
   logic [PACKET_WIDTH-1:0] tx_data;
   logic                    rx_valid;
   logic                    rx_ready;
   logic [PACKET_WIDTH-1:0] rx_data;
   logic [1:0]              nic_addr;
   logic                    nic_en;
   logic                    nic_en_wr;
   logic [PACKET_WIDTH-1:0] nic_d_in;
   logic [PACKET_WIDTH-1:0] nic_d_out;

   modport slave (
      input  tx_valid, tx_data, rx_ready, nic_d_out,
      output tx_ready, rx_valid, rx_data, nic_addr, nic_en, nic_en_wr, nic_d_in
   );

   modport master (
      output tx_valid, tx_data, rx_ready, nic_d_out,
      input  tx_ready, rx_valid, rx_data, nic_addr, nic_en, nic_en_wr, nic_d_in
   );
endinterface

// File: rtl/nic_poll_timer.sv
// Down-counter pacing RX status polls: reload wins over decrement, saturates at zero.
module nic_poll_timer #(
   parameter int POLL_INTERVAL = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic reload_i,
   input  logic dec_i,
   output logic zero_o
);
   localparam int             W      = $clog2(POLL_INTERVAL + 2);
   localparam logic [W-1:0]   RELOAD = W'(POLL_INTERVAL);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (reload_i) begin
         cnt_d = RELOAD;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nic_seq_ctrl.sv
// Sequencer sharing the NIC register bus between TX poll-then-write and RX poll-then-read.
// Optional statistics counters are built when NIC_SEQ_STATS_EN is defined.
module nic_seq_ctrl
   import nic_pkg::*;
#(
   parameter int PACKET_WIDTH  = 64,
   parameter int POLL_INTERVAL = 4
) (
   input  logic          clk,
   input  logic          reset,
   nic_seq_ctrl_if.slave bus
`ifdef NIC_SEQ_STATS_EN
   ,
   output logic [15:0]   tx_sent_cnt,
   output logic [15:0]   rx_recv_cnt,
   output logic [15:0]   busy_retry_cnt
`endif
);

   seq_state_t              state_q, state_d;
   rr_side_t                rr_last_q, rr_last_d;
   logic [PACKET_WIDTH-1:0] hold_q, hold_d;
   logic                    rx_valid_q, rx_valid_d;
   logic [PACKET_WIDTH-1:0] rx_data_q, rx_data_d;

   logic       hold_full;
   logic       tx_accept;
   logic       rx_elig;
   logic       timer_zero;
   logic       timer_reload;
   logic       en_o, wr_o;
   logic [1:0] addr_o;

   // An all-zero packet is indistinguishable from "empty" at the NIC, so it never counts as full.
   assign hold_full = |hold_q;
   assign tx_accept = bus.tx_valid && !hold_full;
   assign rx_elig   = !rx_valid_q && timer_zero;

   nic_poll_timer #(
      .POLL_INTERVAL (POLL_INTERVAL)
   ) u_poll_timer (
      .clk      (clk),
      .reset    (reset),
      .reload_i (timer_reload),
      .dec_i    (!rx_valid_q),
      .zero_o   (timer_zero)
   );

   always_comb begin
      state_d      = state_q;
      rr_last_d    = rr_last_q;
      hold_d       = hold_q;
      rx_valid_d   = rx_valid_q;
      rx_data_d    = rx_data_q;
      en_o         = 1'b0;
      wr_o         = 1'b0;
      addr_o       = NIC_ADDR_IN_BUF;

      if (rx_valid_q && bus.rx_ready) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (hold_full && rx_elig) begin
               state_d = (rr_last_q == TX) ? RX_POLL : TX_POLL;
            end else if (hold_full) begin
               state_d = TX_POLL;
            end else if (rx_elig) begin
               state_d = RX_POLL;
            end
         end
         TX_POLL: begin
            en_o    = 1'b1;
            addr_o  = NIC_ADDR_OUT_STAT;
            state_d = TX_CHK;
         end
         TX_CHK: begin
            if (!bus.nic_d_out[0]) begin
               state_d = TX_WR;
            end else begin
               // Marking TX as last served lets a waiting RX win the next tie.
               rr_last_d = TX;
               state_d   = IDLE;
            end
         end
         TX_WR: begin
            en_o      = 1'b1;
            wr_o      = 1'b1;
            addr_o    = NIC_ADDR_OUT_BUF;
            hold_d    = '0;
            rr_last_d = TX;
            state_d   = IDLE;
         end
         RX_POLL: begin
            en_o    = 1'b1;
            addr_o  = NIC_ADDR_IN_STAT;
            state_d = RX_CHK;
         end
         RX_CHK: begin
            if (bus.nic_d_out[0]) begin
               state_d = RX_RD;
            end else begin
               rr_last_d = RX;
               state_d   = IDLE;
            end
         end
         RX_RD: begin
            en_o    = 1'b1;
            addr_o  = NIC_ADDR_IN_BUF;
            state_d = RX_CAP;
         end
         RX_CAP: begin
            if (|bus.nic_d_out) begin
               rx_data_d  = bus.nic_d_out;
               rx_valid_d = 1'b1;
            end
            rr_last_d = RX;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (tx_accept) begin
         hold_d = bus.tx_data;
      end
   end

   assign timer_reload = (state_d == RX_POLL) && (state_q != RX_POLL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_last_q  <= RX;
         hold_q     <= '0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         hold_q     <= hold_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign bus.tx_ready  = !hold_full;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.nic_en    = en_o;
   assign bus.nic_en_wr = wr_o;
   assign bus.nic_addr  = addr_o;
   assign bus.nic_d_in  = hold_q;

`ifdef NIC_SEQ_STATS_EN
   logic [15:0] tx_sent_q, rx_recv_q, busy_retry_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_sent_q    <= '0;
         rx_recv_q    <= '0;
         busy_retry_q <= '0;
      end else begin
         if (state_q == TX_WR) begin
            tx_sent_q <= tx_sent_q + 16'd1;
         end
         if ((state_q == RX_CAP) && (|bus.nic_d_out)) begin
            rx_recv_q <= rx_recv_q + 16'd1;
         end
         if ((state_q == TX_CHK) && bus.nic_d_out[0]) begin
            busy_retry_q <= busy_retry_q + 16'd1;
         end
      end
   end

   assign tx_sent_cnt    = tx_sent_q;
   assign rx_recv_cnt    = rx_recv_q;
   assign busy_retry_cnt = busy_retry_q;
`endif

endmodule

// File: tb/tb_nic_seq_ctrl.sv
// Directed bench: two sequencers (POLL_INTERVAL 4 and 0), each against a small NIC model.
module tb_nic_seq_ctrl;
   import nic_pkg::*;

   localparam int PW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          tx_valid       [2];
   logic [PW-1:0] tx_data        [2];
   logic          rx_ready       [2];
   logic [31:0]   out_busy_until [2];
   logic [31:0]   in_limit       [2];
   logic [PW-1:0] in_buf         [2];
   logic          log_arm        [2];

   wire           tx_ready_w  [2];
   wire           rx_valid_w  [2];
   wire [PW-1:0]  rx_data_w   [2];
   wire           en_w        [2];
   wire           wr_w        [2];
   wire [1:0]     addr_w      [2];
   wire [PW-1:0]  d_in_w      [2];
   wire [31:0]    wr_cnt      [2];
   wire [PW-1:0]  wr_data     [2];
   wire [31:0]    tx_poll_cnt [2];
   wire [31:0]    rx_poll_cnt [2];
   wire [31:0]    rd_cnt      [2];
   wire [6:0]     log_bits    [2];
   wire [31:0]    log_n       [2];
`ifdef NIC_SEQ_STATS_EN
   wire [15:0]    sent_cnt    [2];
   wire [15:0]    recv_cnt    [2];
   wire [15:0]    retry_cnt   [2];
`endif

   int n_checks = 0;
   int n_fail   = 0;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int PI = (gi == 0) ? 4 : 0;

      nic_seq_ctrl_if #(.PACKET_WIDTH(PW)) bus ();

      logic [PW-1:0] d_out_q = '0;
      logic [31:0]   wr_q    = 0;
      logic [PW-1:0] wd_q    = '0;
      logic [31:0]   txp_q   = 0;
      logic [31:0]   rxp_q   = 0;
      logic [31:0]   rd_q    = 0;
      logic [6:0]    lg_q    = '0;
      logic [31:0]   ln_q    = 0;

      assign bus.tx_valid  = tx_valid[gi];
      assign bus.tx_data   = tx_data[gi];
      assign bus.rx_ready  = rx_ready[gi];
      assign bus.nic_d_out = d_out_q;

      nic_seq_ctrl #(
         .PACKET_WIDTH  (PW),
         .POLL_INTERVAL (PI)
      ) u_dut (
         .clk            (clk),
         .reset          (rst),
         .bus            (bus)
`ifdef NIC_SEQ_STATS_EN
         ,
         .tx_sent_cnt    (sent_cnt[gi]),
         .rx_recv_cnt    (recv_cnt[gi]),
         .busy_retry_cnt (retry_cnt[gi])
`endif
      );

      // NIC model: registered d_out, status driven by bench-set thresholds on poll/read counts.
      always @(posedge clk) begin
         if (bus.nic_en) begin
            if (bus.nic_en_wr) begin
               if (bus.nic_addr == NIC_ADDR_OUT_BUF) begin
                  wr_q <= wr_q + 1;
                  wd_q <= bus.nic_d_in;
               end
            end else begin
               case (bus.nic_addr)
                  NIC_ADDR_OUT_STAT: begin
                     d_out_q <= PW'(txp_q < out_busy_until[gi]);
                     txp_q   <= txp_q + 1;
                  end
                  NIC_ADDR_IN_STAT: begin
                     d_out_q <= PW'(rd_q < in_limit[gi]);
                     rxp_q   <= rxp_q + 1;
                  end
                  default: begin
                     d_out_q <= in_buf[gi];
                     rd_q    <= rd_q + 1;
                  end
               endcase
            end
         end
         if (!log_arm[gi]) begin
            ln_q <= 0;
         end else if ((ln_q < 7) && bus.nic_en && !bus.nic_en_wr) begin
            if (bus.nic_addr == NIC_ADDR_OUT_STAT) begin
               lg_q <= {lg_q[5:0], 1'b0};
               ln_q <= ln_q + 1;
            end else if ((bus.nic_addr == NIC_ADDR_IN_STAT) && (ln_q != 0)) begin
               lg_q <= {lg_q[5:0], 1'b1};
               ln_q <= ln_q + 1;
            end
         end
      end

      assign tx_ready_w[gi]  = bus.tx_ready;
      assign rx_valid_w[gi]  = bus.rx_valid;
      assign rx_data_w[gi]   = bus.rx_data;
      assign en_w[gi]        = bus.nic_en;
      assign wr_w[gi]        = bus.nic_en_wr;
      assign addr_w[gi]      = bus.nic_addr;
      assign d_in_w[gi]      = bus.nic_d_in;
      assign wr_cnt[gi]      = wr_q;
      assign wr_data[gi]     = wd_q;
      assign tx_poll_cnt[gi] = txp_q;
      assign rx_poll_cnt[gi] = rxp_q;
      assign rd_cnt[gi]      = rd_q;
      assign log_bits[gi]    = lg_q;
      assign log_n[gi]       = ln_q;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] b_wr  [2];
      logic [31:0] b_txp [2];
      logic [31:0] b_rxp;
      logic        found;

      for (int i = 0; i < 2; i++) begin
         tx_valid[i]       = 1'b0;
         tx_data[i]        = '0;
         rx_ready[i]       = 1'b1;
         out_busy_until[i] = 0;
         in_limit[i]       = 0;
         in_buf[i]         = '0;
         log_arm[i]        = 1'b0;
      end

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_tx_ready", tx_ready_w[0], 1);
      check_eq("rst_rx_valid", rx_valid_w[0], 0);
      check_eq("rst_rx_data",  rx_data_w[0], 0);
      check_eq("rst_nic_en",   en_w[0], 0);
      check_eq("rst_nic_wr",   wr_w[0], 0);
      check_eq("rst_nic_addr", addr_w[0], 0);
      check_eq("rst_nic_d_in", d_in_w[0], 0);
      $display("reset checked");

      // 1: single TX, NIC out buffer empty; exact cycle timing on PI=4 instance
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tx_valid[i] = 1'b1;
         tx_data[i]  = 64'h0000_0000_DEAD_BEEF;
      end
      @(negedge clk);
      check_eq("t1_hold_full", tx_ready_w[0], 0);
      for (int i = 0; i < 2; i++) tx_valid[i] = 1'b0;
      @(negedge clk);
      check_eq("t1_poll_bus", {en_w[0], wr_w[0], addr_w[0]}, 4'b1011);
      @(negedge clk);
      check_eq("t1_chk_idle", en_w[0], 0);
      @(negedge clk);
      check_eq("t1_wr_bus",  {en_w[0], wr_w[0], addr_w[0]}, 4'b1110);
      check_eq("t1_wr_data", d_in_w[0], 64'h0000_0000_DEAD_BEEF);
      @(negedge clk);
      check_eq("t1_ready_back", tx_ready_w[0], 1);
      check_eq("t1_wr_count",   wr_cnt[0], 1);
      $display("tx1 data=%h written", wr_data[0]);

      // 2: out status busy for two polls, then free
      repeat (10) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         b_wr[i]           = wr_cnt[i];
         b_txp[i]          = tx_poll_cnt[i];
         out_busy_until[i] = tx_poll_cnt[i] + 2;
         tx_valid[i]       = 1'b1;
         tx_data[i]        = 64'h0000_0000_1234_5678;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) tx_valid[i] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 80 && !found; c++) begin
         @(negedge clk);
         if ((wr_cnt[0] != b_wr[0]) && (wr_cnt[1] != b_wr[1])) found = 1'b1;
      end
      check_eq("t2_write_seen", found, 1);
      for (int i = 0; i < 2; i++) begin
         check_eq("t2_tx_polls", tx_poll_cnt[i] - b_txp[i], 3);
         check_eq("t2_wr_data",  wr_data[i], 64'h0000_0000_1234_5678);
      end
`ifdef NIC_SEQ_STATS_EN
      check_eq("t2_stat_retry", retry_cnt[0], 2);
      check_eq("t2_stat_sent",  sent_cnt[0], 2);
`endif
      $display("tx2 data=%h written after retries", wr_data[0]);

      // 3: RX packet, latency from RX_POLL, back-pressure holds rx_valid
      for (int i = 0; i < 2; i++) begin
         rx_ready[i] = 1'b0;
         in_buf[i]   = 64'h00AA_0001_0000_0042;
         in_limit[i] = rd_cnt[i] + 1;
      end
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (en_w[0] && !wr_w[0] && (addr_w[0] == NIC_ADDR_IN_STAT)) found = 1'b1;
         else @(negedge clk);
      end
      check_eq("t3_poll_seen", found, 1);
      repeat (3) @(negedge clk);
      check_eq("t3_valid_early", rx_valid_w[0], 0);
      @(negedge clk);
      check_eq("t3_valid_at4", rx_valid_w[0], 1);
      check_eq("t3_rx_data",   rx_data_w[0], 64'h00AA_0001_0000_0042);
      b_rxp = rx_poll_cnt[0];
      repeat (10) @(negedge clk);
      check_eq("t3_no_repoll", rx_poll_cnt[0] - b_rxp, 0);
      check_eq("t3_valid_held", rx_valid_w[0], 1);
      for (int i = 0; i < 2; i++) rx_ready[i] = 1'b1;
      @(negedge clk);
      check_eq("t3_valid_clear", rx_valid_w[0], 0);
`ifdef NIC_SEQ_STATS_EN
      check_eq("t3_stat_recv", recv_cnt[0], 1);
`endif
      $display("rx data=%h received", rx_data_w[0]);

      // 4: TX blocked by busy status while RX keeps polling: strict alternation
      repeat (5) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         b_wr[i]           = wr_cnt[i];
         b_txp[i]          = tx_poll_cnt[i];
         out_busy_until[i] = tx_poll_cnt[i] + 3;
         log_arm[i]        = 1'b1;
         tx_valid[i]       = 1'b1;
         tx_data[i]        = 64'h0000_0000_0000_0F0F;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) tx_valid[i] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if ((wr_cnt[0] != b_wr[0]) && (wr_cnt[1] != b_wr[1])) found = 1'b1;
      end
      check_eq("t4_write_seen", found, 1);
      for (int i = 0; i < 2; i++) begin
         check_eq("t4_log_len",   log_n[i], 7);
         check_eq("t4_alternate", log_bits[i], 7'b0101010);
         check_eq("t4_tx_polls",  tx_poll_cnt[i] - b_txp[i], 4);
         log_arm[i] = 1'b0;
      end
      $display("arb sequence pi4=%b pi0=%b", log_bits[0], log_bits[1]);

      // 5: zero packet accepted and dropped
      for (int i = 0; i < 2; i++) begin
         b_wr[i]     = wr_cnt[i];
         b_txp[i]    = tx_poll_cnt[i];
         tx_valid[i] = 1'b1;
         tx_data[i]  = '0;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_eq("t5_ready", tx_ready_w[i], 1);
         tx_valid[i] = 1'b0;
      end
      repeat (20) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_eq("t5_no_poll",  tx_poll_cnt[i] - b_txp[i], 0);
         check_eq("t5_no_write", wr_cnt[i] - b_wr[i], 0);
      end
      $display("tx zero packet dropped");

      // 6: reset during TX_CHK abandons the transfer
      for (int i = 0; i < 2; i++) begin
         tx_valid[i] = 1'b1;
         tx_data[i]  = 64'h0000_0000_0000_CAFE;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) tx_valid[i] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (en_w[0] && !wr_w[0] && (addr_w[0] == NIC_ADDR_OUT_STAT)) found = 1'b1;
         else @(negedge clk);
      end
      check_eq("t6_poll_seen", found, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("t6_rst_ready", tx_ready_w[0], 1);
      check_eq("t6_rst_en",    en_w[0], 0);
      check_eq("t6_rst_d_in",  d_in_w[0], 0);
      @(negedge clk);
      rst = 1'b0;
      b_wr[0]  = wr_cnt[0];
      b_txp[0] = tx_poll_cnt[0];
      repeat (20) @(negedge clk);
      check_eq("t6_no_write", wr_cnt[0] - b_wr[0], 0);
      check_eq("t6_no_poll",  tx_poll_cnt[0] - b_txp[0], 0);
`ifdef NIC_SEQ_STATS_EN
      check_eq("t6_stat_sent_rst", sent_cnt[0], 0);
`endif
      $display("reset mid-transfer dropped packet");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
